// File: rtl/vga_pixel_fetch.sv
// Three-stage pixel fetch: word address -> one-cycle memory read -> bit select and colour map.
// Optional FETCH_REUSE_EN: skip reads that hit the last issued word address and reuse the held word.
module vga_pixel_fetch #(
    parameter int BORDER_ADDR = 32384,
    parameter int Y_START     = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic [15:0] cell_addr,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        video_on_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_rd_data,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic [7:0]  cfg_data,
    output logic [7:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_on_out
);

    localparam logic [15:0] BORDER_WORD = 16'(BORDER_ADDR);
    localparam logic [10:0] Y_FIRST     = 11'(Y_START);

    logic [10:0] w_row_diff;
    logic [2:0]  w_row;
    logic        w_half;
    logic [15:0] w_word_addr;
    logic        w_border;
    logic [3:0]  w_bitsel;
    logic        w_hit;
    logic        w_rd;
    logic [15:0] w_word;
    logic [7:0]  w_rgb_next;
    logic        w_unused;

    logic [15:0] r_mem_addr;
    logic        r_s1_valid;
    logic        r_s1_border;
    logic        r_s1_rd;
    logic [3:0]  r_s1_bitsel;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_von;

    logic        r_s2_valid;
    logic        r_s2_border;
    logic [3:0]  r_s2_bitsel;
    logic        r_s2_hs;
    logic        r_s2_vs;
    logic        r_s2_von;

    logic [7:0]  r_rgb;
    logic        r_hs_out;
    logic        r_vs_out;
    logic        r_von_out;

    logic [7:0]  r_fg;
    logic [7:0]  r_bg;
    logic [7:0]  r_bd;

    // Rows above the text region always arrive with the border address, so a wrapped row is harmless.
    assign w_row_diff  = pixel_y - Y_FIRST;
    assign w_row       = w_row_diff[2:0];
    assign w_half      = pixel_x[4];
    assign w_word_addr = cell_addr + {12'd0, w_row, w_half};
    assign w_border    = (cell_addr == BORDER_WORD);
    assign w_bitsel    = 4'd15 - pixel_x[3:0];
    assign w_unused    = &{pixel_x[10:5], w_row_diff[10:3]};

`ifdef FETCH_REUSE_EN
    logic [15:0] r_last_addr;
    logic        r_last_valid;
    logic        r_s2_rd;
    logic [15:0] r_word;

    assign w_hit  = r_last_valid && (w_word_addr == r_last_addr);
    assign w_word = r_s2_rd ? mem_rd_data : r_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_valid <= 1'b0;
            r_last_addr  <= 16'd0;
            r_s2_rd      <= 1'b0;
            r_word       <= 16'd0;
        end else begin
            if (w_rd) begin
                r_last_valid <= 1'b1;
                r_last_addr  <= w_word_addr;
            end
            r_s2_rd <= r_s1_rd;
            if (r_s2_valid && r_s2_rd) begin
                r_word <= mem_rd_data;
            end
        end
    end
`else
    assign w_hit  = 1'b0;
    assign w_word = mem_rd_data;
`endif

    assign w_rd = video_on_in & ~w_border & ~w_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= 16'd0;
            r_s1_valid  <= 1'b0;
            r_s1_border <= 1'b0;
            r_s1_rd     <= 1'b0;
            r_s1_bitsel <= 4'd0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
            r_s1_von    <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_border <= 1'b0;
            r_s2_bitsel <= 4'd0;
            r_s2_hs     <= 1'b1;
            r_s2_vs     <= 1'b1;
            r_s2_von    <= 1'b0;
        end else begin
            r_mem_addr  <= w_word_addr;
            r_s1_valid  <= 1'b1;
            r_s1_border <= w_border;
            r_s1_rd     <= w_rd;
            r_s1_bitsel <= w_bitsel;
            r_s1_hs     <= hsync_in;
            r_s1_vs     <= vsync_in;
            r_s1_von    <= video_on_in;
            r_s2_valid  <= r_s1_valid;
            r_s2_border <= r_s1_border;
            r_s2_bitsel <= r_s1_bitsel;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
            r_s2_von    <= r_s1_von;
        end
    end

    always_comb begin
        w_rgb_next = 8'h00;
        if (r_s2_valid && r_s2_von) begin
            if (r_s2_border) begin
                w_rgb_next = r_bd;
            end else if (w_word[r_s2_bitsel]) begin
                w_rgb_next = r_fg;
            end else begin
                w_rgb_next = r_bg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb     <= 8'h00;
            r_hs_out  <= 1'b1;
            r_vs_out  <= 1'b1;
            r_von_out <= 1'b0;
        end else begin
            r_rgb     <= w_rgb_next;
            r_hs_out  <= r_s2_hs;
            r_vs_out  <= r_s2_vs;
            r_von_out <= r_s2_valid & r_s2_von;
        end
    end

    // Registered write: a lookup in the same cycle as the write still sees the old colour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fg <= 8'hFF;
            r_bg <= 8'h00;
            r_bd <= 8'h03;
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    r_fg <= cfg_data;
                2'd1:    r_bg <= cfg_data;
                2'd2:    r_bd <= cfg_data;
                default: ;
            endcase
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_rd_en    = r_s1_rd;
    assign rgb          = r_rgb;
    assign hsync_out    = r_hs_out;
    assign vsync_out    = r_vs_out;
    assign video_on_out = r_von_out;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: per-cycle expectations checked at 3-cycle (colour/sync)
// and 1-cycle (read port) offsets against a one-cycle-latency memory model.
module tb_vga_pixel_fetch;

`ifdef FETCH_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif
    localparam logic [15:0] BORDER = 16'd32384;
    localparam logic [31:0] ROW81_BITS = 32'hC003_8001;

    logic        clk;
    logic        reset;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [15:0] cell_addr;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on_in;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rd_data;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [7:0]  cfg_data;
    logic [7:0]  rgb;
    logic        hsync_out;
    logic        vsync_out;
    logic        video_on_out;

    int n_checks;
    int n_errors;
    int cyc;
    logic        last_valid;
    logic [15:0] last_addr;

    logic        e_on   [0:1023];
    logic [7:0]  e_rgb  [0:1023];
    logic        e_hs   [0:1023];
    logic        e_vs   [0:1023];
    logic        e_von  [0:1023];
    logic        e_mon  [0:1023];
    logic        e_mrd  [0:1023];
    logic [15:0] e_maddr[0:1023];

    vga_pixel_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .cell_addr    (cell_addr),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .video_on_in  (video_on_in),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .rgb          (rgb),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .video_on_out (video_on_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'd16386: return 16'h8001;
            16'd16387: return 16'hC003;
            16'd16415: return 16'hF00F;
            default:   return 16'h0000;
        endcase
    endfunction

    // Unrequested cycles return junk so a design that skips a read must use its held word.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_word(mem_addr) : 16'h5A5A;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= 3 && e_on[cyc-3]) begin
            check("rgb",      32'(rgb),          32'(e_rgb[cyc-3]));
            check("hsync",    32'(hsync_out),    32'(e_hs[cyc-3]));
            check("vsync",    32'(vsync_out),    32'(e_vs[cyc-3]));
            check("video_on", 32'(video_on_out), 32'(e_von[cyc-3]));
        end
        if (cyc >= 1 && e_mon[cyc-1]) begin
            check("mem_rd_en", 32'(mem_rd_en), 32'(e_mrd[cyc-1]));
            if (e_mrd[cyc-1]) check("mem_addr", 32'(mem_addr), 32'(e_maddr[cyc-1]));
        end
    endtask

    task automatic pix(input int x, input int y, input logic [15:0] addr, input logic hs,
                       input logic vs, input logic von, input logic [7:0] er, input logic [15:0] ema);
        logic rd;
        pixel_x     = 11'(x);
        pixel_y     = 11'(y);
        cell_addr   = addr;
        hsync_in    = hs;
        vsync_in    = vs;
        video_on_in = von;
        rd = von && (addr != BORDER) && !(REUSE && last_valid && (ema == last_addr));
        if (rd) begin
            last_valid = 1'b1;
            last_addr  = ema;
        end
        e_on[cyc]    = 1'b1;
        e_rgb[cyc]   = er;
        e_hs[cyc]    = hs;
        e_vs[cyc]    = vs;
        e_von[cyc]   = von;
        e_mon[cyc]   = 1'b1;
        e_mrd[cyc]   = rd;
        e_maddr[cyc] = ema;
        tick();
    endtask

    function automatic logic [7:0] glyph81(input int x, input logic [7:0] fg, input logic [7:0] bg);
        logic [31:0] pat;
        pat = ROW81_BITS;
        return pat[x] ? fg : bg;
    endfunction

    task automatic reset_mid();
        int r;
        r = cyc;
        reset       = 1'b1;
        pixel_x     = 11'd4;
        pixel_y     = 11'd81;
        cell_addr   = 16'd16384;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        video_on_in = 1'b1;
        for (int i = r - 2; i <= r; i++) begin
            e_on[i]  = 1'b1;
            e_rgb[i] = 8'h00;
            e_hs[i]  = 1'b1;
            e_vs[i]  = 1'b1;
            e_von[i] = 1'b0;
        end
        e_mon[r] = 1'b1;
        e_mrd[r] = 1'b0;
        tick();
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset      = 1'b0;
        last_valid = 1'b0;
    endtask

    initial begin
        int rd_cnt;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        last_valid = 1'b0;
        last_addr  = 16'd0;
        for (int i = 0; i < 1024; i++) begin
            e_on[i]  = 1'b0;
            e_mon[i] = 1'b0;
        end
        cfg_we      = 1'b0;
        cfg_sel     = 2'd0;
        cfg_data    = 8'h00;
        reset       = 1'b1;
        pixel_x     = 11'd0;
        pixel_y     = 11'd81;
        cell_addr   = 16'd16384;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        video_on_in = 1'b1;

        tick();
        check("rst_rgb",      32'(rgb),          32'h00);
        check("rst_hsync",    32'(hsync_out),    32'd1);
        check("rst_vsync",    32'(vsync_out),    32'd1);
        check("rst_video_on", 32'(video_on_out), 32'd0);
        check("rst_rd_en",    32'(mem_rd_en),    32'd0);
        check("rst_mem_addr", 32'(mem_addr),     32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Border pixels: border colour, never a read; blanking wins over border.
        pix(5, 40, BORDER, 1'b1, 1'b1, 1'b1, 8'h03, 16'd0);
        pix(6, 40, BORDER, 1'b1, 1'b1, 1'b1, 8'h03, 16'd0);
        pix(7, 40, BORDER, 1'b1, 1'b1, 1'b1, 8'h03, 16'd0);
        pix(8, 40, BORDER, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0);

        // Row 1 of cell 16384 -> word 16386 = 8001: only leftmost and rightmost pixels set.
        for (int x = 0; x < 16; x++)
            pix(x, 81, 16'd16384, 1'b1, 1'b1, 1'b1, (x == 0 || x == 15) ? 8'hFF : 8'h00, 16'd16386);

        // Row 7, right half of cell 16400 -> word 16415 = F00F.
        pix(16, 87, 16'd16400, 1'b1, 1'b1, 1'b1, 8'hFF, 16'd16415);
        pix(20, 87, 16'd16400, 1'b1, 1'b1, 1'b1, 8'h00, 16'd16415);
        pix(31, 87, 16'd16400, 1'b1, 1'b1, 1'b1, 8'hFF, 16'd16415);

        pix(0, 81, 16'd16384, 1'b1, 1'b1, 1'b0, 8'h00, 16'd16386);

        // Foreground write on cycle N: pixel at N-2 keeps FF, pixels at N-1 and N get E0.
        pix(0, 81, 16'd16384, 1'b1, 1'b1, 1'b1, 8'hFF, 16'd16386);
        pix(15, 81, 16'd16384, 1'b1, 1'b1, 1'b1, 8'hE0, 16'd16386);
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'hE0;
        pix(0, 81, 16'd16384, 1'b1, 1'b1, 1'b1, 8'hE0, 16'd16386);
        cfg_sel = 2'd1; cfg_data = 8'h1C;
        pix(1, 81, 16'd16384, 1'b1, 1'b1, 1'b1, 8'h1C, 16'd16386);
        cfg_sel = 2'd2; cfg_data = 8'hC3;
        pix(9, 40, BORDER, 1'b1, 1'b1, 1'b1, 8'hC3, 16'd0);
        cfg_sel = 2'd3; cfg_data = 8'h55;
        pix(0, 81, 16'd16384, 1'b1, 1'b1, 1'b1, 8'hE0, 16'd16386);
        cfg_we = 1'b0;
        pix(14, 81, 16'd16384, 1'b1, 1'b1, 1'b1, 8'h1C, 16'd16386);
        pix(10, 40, BORDER, 1'b1, 1'b1, 1'b1, 8'hC3, 16'd0);

        // Horizontal sync pulse during blanking, then a short vertical sync.
        pix(0, 0, BORDER, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0);
        pix(0, 0, BORDER, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0);
        for (int i = 0; i < 96; i++)
            pix(i, 0, BORDER, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
        for (int i = 0; i < 4; i++)
            pix(i, 0, BORDER, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0);
        pix(0, 0, BORDER, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        pix(0, 0, BORDER, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0);
        pix(0, 0, BORDER, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0);

        // Reset mid-line with syncs active: in-flight pixels must not reach the outputs.
        pix(0, 81, 16'd16384, 1'b0, 1'b0, 1'b1, 8'hE0, 16'd16386);
        pix(1, 81, 16'd16384, 1'b0, 1'b0, 1'b1, 8'h1C, 16'd16386);
        pix(2, 81, 16'd16384, 1'b0, 1'b0, 1'b1, 8'h1C, 16'd16386);
        pix(3, 81, 16'd16384, 1'b0, 1'b0, 1'b1, 8'h1C, 16'd16386);
        reset_mid();

        // One full 32-pixel line after reset: default colours, two reads with reuse, 32 without.
        rd_cnt = 0;
        for (int x = 0; x < 32; x++) begin
            pix(x, 81, 16'd16384, 1'b1, 1'b1, 1'b1, glyph81(x, 8'hFF, 8'h00),
                (x < 16) ? 16'd16386 : 16'd16387);
            rd_cnt += int'(mem_rd_en);
        end
        check("rd_pulses", 32'(rd_cnt), REUSE ? 32'd2 : 32'd32);

        for (int i = 0; i < 4; i++)
            pix(0, 0, BORDER, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Downstream consumer of the tile address generator in the VGA display path. Takes the 16-bit cell base address plus the raw pixel coordinates, fetches the 16-bit glyph word from video memory through a one-cycle-latency synchronous read port, selects the pixel's bit, and maps it to an 8-bit colour. Sync and blank signals are delayed so they stay aligned with the colour output at the DAC pins.

## Interface
Parameters:
- `BORDER_ADDR`, default 32384: address-generator value that marks a pixel outside the text region.
- `Y_START`, default 80: first screen line of the text region.

Ports (`clk` and `reset` first):
- `clk`  in  1: pixel clock. It is the only clock.
- `reset`  in  1: synchronous, active-high.
- `pixel_x`  in  11: current pixel column.
- `pixel_y`  in  11: current pixel line.
- `cell_addr`  in  16: cell base address from the address generator. It is valid in the same cycle as `pixel_x` and `pixel_y`.
- `hsync_in`, `vsync_in`  in  1: active-low syncs from the timing generator.
- `video_on_in`  in  1: high when inside the visible area.
- `mem_addr`  out  16: registered read address to video memory.
- `mem_rd_en`  out  1: read strobe.
- `mem_rd_data`  in  16: memory data, valid exactly one cycle after `mem_addr`/`mem_rd_en`.
- `cfg_we`  in  1: colour register write enable.
- `cfg_sel`  in  2: colour register select. 0 = foreground, 1 = background, 2 = border, 3 = ignored.
- `cfg_data`  in  8: colour value, RRRGGGBB.
- `rgb`  out  8: pixel colour.
- `hsync_out`, `vsync_out`, `video_on_out`  out  1: delayed copies of the sync and blank inputs.

## Operation
The block is a three-stage pipeline. Each stage carries `valid`, `border`, `bitsel[3:0]`, and the sync and blank bits.

- **S0 (address).**
  - `border` = (`cell_addr` == `BORDER_ADDR`).
  - `row` = (`pixel_y` − `Y_START`)[2:0].
  - `half` = `pixel_x`[4].
  - Word address = `cell_addr` + {row, half}, i.e. `cell_addr` + row·2 + half, 16-bit add with wrap.
  - `bitsel` = 15 − `pixel_x`[3:0]; the MSB of the word is the leftmost pixel.
  - `mem_addr` is registered from the word address.
  - `mem_rd_en` = `video_on_in` & ~`border`.
- **S1 (memory).** Waits one cycle while memory returns data. The returned word is captured as `word` at the end of S1.
- **S2 (colour).** `rgb` is registered as follows:
  - `video_on` = 0 → 8'h00.
  - else `border` = 1 → border register.
  - else `word`[`bitsel`] = 1 → foreground register.
  - else → background register.
- **Colour registers.** When `cfg_we` = 1, the register selected by `cfg_sel` loads `cfg_data` at the clock edge. `cfg_sel` = 3 is a no-op.
  - A write on cycle N is used by any pixel that computes its S2 colour on cycle N+1 or later.
  - A write and a colour lookup in the same cycle: the lookup uses the old value.
- **Region boundary.** `pixel_y` < `Y_START` is always paired with `BORDER_ADDR`, so the wrapped `row` value is never used.
- **Reset.** All stage `valid` bits clear. Reset values:
  - `rgb` = 0, `video_on_out` = 0.
  - `hsync_out` = 1, `vsync_out` = 1 (inactive).
  - `mem_rd_en` = 0, `mem_addr` = 0.
  - foreground = 8'hFF, background = 8'h00, border = 8'h03.
- **Reset mid-frame.** In-flight pixels are discarded; no stale colour appears after reset deasserts. The first valid output is the pixel presented 3 cycles after the first non-reset cycle.

## Timing
- Fixed latency of 3 clocks, input to `rgb`/`hsync_out`/`vsync_out`/`video_on_out`, one pixel per clock, no stalls.
- `mem_addr` and `mem_rd_en` are valid 1 clock after the input. Data is expected 1 clock after that.
- Syncs pass through a 3-deep shift register so they are bit-aligned with `rgb`.
- No backpressure: memory must answer every `mem_rd_en` with fixed 1-cycle latency.

## Configuration
- Macro: `FETCH_REUSE_EN`.
- **Defined.**
  - S0 compares the new word address with the last issued one. A match is only valid if the previous issued read was not reset-cleared.
  - On a match: `mem_rd_en` = 0, and S1 keeps the held `word` instead of sampling `mem_rd_data`.
  - Effect: at most one read per 16 consecutive pixels of a line.
  - Latency and output are identical to the undefined case.
  - Reset invalidates the held word.
- **Undefined.** Every visible non-border pixel issues a read. The comparator and hold logic are not built.

## Test plan
- **Border pixel.** Reset, then present `cell_addr` = 32384, `video_on_in` = 1 → 3 cycles later `rgb` = 8'h03, and `mem_rd_en` stays 0.
- **Glyph bit select.** `cell_addr` = 16384, `pixel_x` = 0..15, `pixel_y` = 81, memory word at 16386 = 16'h8001 → `mem_addr` = 16386. `rgb` is FF for x=0, 00 for x=1..14, FF for x=15.
- **Second half-word.** `pixel_x` = 16, `pixel_y` = 87, `cell_addr` = 16400 → `mem_addr` = 16400 + 14 + 1 = 16415.
- **Colour write.** Colour write on cycle N (`cfg_sel` = 0, data 8'hE0), with a visible set-bit pixel presented on cycle N−1 → its `rgb` at N+2 = 8'hE0. A pixel presented at N−2 still shows the old value 8'hFF.
- **Blank and sync alignment.** `hsync_in` pulse low for 96 cycles with `video_on_in` = 0 → `hsync_out` is low exactly 3 cycles later for 96 cycles, and `rgb` = 0 throughout.
- **Reset and reuse.** Reset asserted mid-line → next cycle outputs are at reset values. With `FETCH_REUSE_EN`, 32 pixels from x=0 on one line give exactly 2 `mem_rd_en` pulses and the same `rgb` as the non-reuse build.
